// File: rtl/serial_ripple_subtractor_if.sv
// Request/result bundle for serial_ripple_subtractor.
// The ovf signal exists only when SUB_OVERFLOW_EN is defined.
interface serial_ripple_subtractor_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic [WIDTH-1:0] borrows;
`ifdef SUB_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
`ifdef SUB_OVERFLOW_EN
    input  ovf,
`endif
    input  busy, done, diff, bout, borrows
  );

  modport slave (
    input  start, a, b, bin,
`ifdef SUB_OVERFLOW_EN
    output ovf,
`endif
    output busy, done, diff, bout, borrows
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Define SUB_OVERFLOW_EN to add the signed-overflow output (ovf).
module serial_ripple_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  serial_ripple_subtractor_if.slave    bus
);
  localparam int unsigned IdxW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] diff_q, borrows_q;
  logic [IdxW-1:0]  idx_q;
  logic             br_q, bout_q, busy_q, done_q;
  logic             diff_bit, borrow_bit;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_q;
`endif

  // Single full-subtractor cell fed from the LSBs of the operand shift registers.
  always_comb begin
    diff_bit   = a_q[0] ^ b_q[0] ^ br_q;
    borrow_bit = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      borrows_q <= '0;
      idx_q     <= '0;
      br_q      <= 1'b0;
      bout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q       <= bus.a;
            b_q       <= bus.b;
            br_q      <= bus.bin;
            diff_q    <= '0;
            borrows_q <= '0;
            bout_q    <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= StRun;
`ifdef SUB_OVERFLOW_EN
            ovf_q     <= 1'b0;
`endif
          end
        end
        StRun: begin
          diff_q[idx_q]    <= diff_bit;
          borrows_q[idx_q] <= borrow_bit;
          br_q             <= borrow_bit;
          a_q              <= a_q >> 1;
          b_q              <= b_q >> 1;
          if (idx_q == IdxW'(WIDTH - 1)) begin
            bout_q  <= borrow_bit;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
`ifdef SUB_OVERFLOW_EN
            // Borrow into the sign bit differs from borrow out of it.
            ovf_q   <= borrow_bit ^ borrows_q[WIDTH-2];
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.diff    = diff_q;
  assign bus.bout    = bout_q;
  assign bus.borrows = borrows_q;
`ifdef SUB_OVERFLOW_EN
  assign bus.ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed plus randomized bench for serial_ripple_subtractor (WIDTH=4), checked against an
// arithmetic reference model.
module tb_serial_ripple_subtractor;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  serial_ripple_subtractor_if #(.WIDTH(W)) bus ();

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] ref_diff(input int a, input int b, input int bin);
    return W'((a - b - bin) & ((1 << W) - 1));
  endfunction

  function automatic logic ref_bout(input int a, input int b, input int bin);
    return a < b + bin;
  endfunction

  // borrows[i] is the borrow out of the low i+1 bits of the subtraction.
  function automatic logic [W-1:0] ref_borrows(input int a, input int b, input int bin);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      int m;
      m = (1 << (i + 1)) - 1;
      r[i] = (a & m) < ((b & m) + bin);
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int a, input int b, input int bin);
    int sa, sb, r;
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    r  = sa - sb - bin;
    return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
  endfunction

  task automatic check_result(input string tag, input int a, input int b, input int bin);
    check({tag, ".diff"}, 32'(bus.diff), 32'(ref_diff(a, b, bin)));
    check({tag, ".bout"}, 32'(bus.bout), 32'(ref_bout(a, b, bin)));
    check({tag, ".borrows"}, 32'(bus.borrows), 32'(ref_borrows(a, b, bin)));
`ifdef SUB_OVERFLOW_EN
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(ref_ovf(a, b, bin)));
`endif
  endtask

  // Launch one operation; optionally pulse a competing start on RUN cycle 2.
  task automatic run_op(input string tag, input int a, input int b, input int bin,
                        input bit interfere, input bit timing);
    int lat, busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = W'(a);
    bus.b = W'(b);
    bus.bin = 1'(bin);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (1) begin
      if (bus.busy) busy_cnt++;
      if (bus.done || lat > 20) break;
      if (interfere && lat == 2) begin
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = '0;
        bus.b = 4'b0001;
        bus.bin = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
    end
    check({tag, ".done_seen"}, 32'(bus.done), 32'd1);
    if (timing) begin
      check({tag, ".latency"}, lat, W + 1);
      check({tag, ".busy_cycles"}, busy_cnt, W);
    end
    check_result(tag, a, b, bin);
    @(posedge clk);
    #1;
    if (timing) begin
      check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, ".hold_diff"}, 32'(bus.diff), 32'(ref_diff(a, b, bin)));
    end
  endtask

  initial begin
    int d1, d2, cyc;
    bit saw_done;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.done", 32'(bus.done), 0);
    check("rst.diff", 32'(bus.diff), 0);
    check("rst.bout", 32'(bus.bout), 0);
    check("rst.borrows", 32'(bus.borrows), 0);
`ifdef SUB_OVERFLOW_EN
    check("rst.ovf", 32'(bus.ovf), 0);
`endif
    rst = 1'b0;

    run_op("d0", 'b1011, 'b0110, 0, 0, 1);
    check("d0.borrows_lit", 32'(bus.borrows), 32'b0100);
    run_op("d1", 'b0000, 'b0001, 0, 0, 1);
    run_op("d2", 'b0000, 'b0000, 1, 0, 1);
    run_op("d3", 'b1111, 'b1111, 1, 0, 1);
    check("d3.borrows_lit", 32'(bus.borrows), 32'b1111);
`ifdef SUB_OVERFLOW_EN
    run_op("ov0", 'b0111, 'b1111, 0, 0, 1);
    check("ov0.ovf_lit", 32'(bus.ovf), 1);
    run_op("ov1", 'b0011, 'b0001, 0, 0, 1);
    check("ov1.ovf_lit", 32'(bus.ovf), 0);
`endif

    // Start during RUN must be ignored.
    run_op("intf", 'b1011, 'b0110, 0, 1, 1);
    check("intf.diff_lit", 32'(bus.diff), 32'b0101);
    @(posedge clk);
    #1;
    check("intf.no_queue", 32'(bus.busy), 0);

    // Reset on RUN cycle 2 discards the operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'b1011;
    bus.b = 4'b0110;
    bus.bin = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst.busy", 32'(bus.busy), 0);
    check("mrst.done", 32'(bus.done), 0);
    check("mrst.diff", 32'(bus.diff), 0);
    check("mrst.bout", 32'(bus.bout), 0);
    check("mrst.borrows", 32'(bus.borrows), 0);
    saw_done = 0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1;
    end
    check("mrst.no_done", 32'(saw_done), 0);

    // Held start: one acceptance per W+2 cycles.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'd9;
    bus.b = 4'd3;
    bus.bin = 1'b0;
    d1 = -1;
    d2 = -1;
    cyc = 0;
    while (d2 < 0 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) begin
        if (d1 < 0) d1 = cyc;
        else d2 = cyc;
      end
    end
    check("held.second_done", 32'(d2 >= 0), 1);
    check("held.period", d2 - d1, W + 2);
    check_result("held", 9, 3, 0);
    bus.start = 1'b0;
    repeat (W + 3) @(posedge clk);

    for (int n = 0; n < 30; n++) begin
      int ra, rb, rbin;
      ra = int'($urandom_range(0, (1 << W) - 1));
      rb = int'($urandom_range(0, (1 << W) - 1));
      rbin = int'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", n), ra, rb, rbin, 0, (n % 5) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
